clk_wiz: RTL and testbench

- Synthesizable clock generator that derives two divided clocks from a single input clock.
- Also produces a lock indicator.
- Sits between the board/external clock and the emulator fabric: clk_out1 drives the emulator clock domain, clk_out2 drives the debug hub.
- Both outputs are phase-aligned to the same clk_in1 edge after reset.

---
 rtl/clk_wiz_if.sv | 19 +
 rtl/clk_wiz.sv | 116 +++++++++++
 tb/tb_clk_wiz.sv | 105 ++++++++++
 3 files changed

// File: rtl/clk_wiz_if.sv
// Output bundle of the clock generator: both divided clocks plus lock status.
// The generator drives it as master, consumers observe it as slave.
interface clk_wiz_if;
   logic clk_out1;
   logic clk_out2;
   logic locked;

   modport master (
      output clk_out1,
      output clk_out2,
      output locked
   );

   modport slave (
      input clk_out1,
      input clk_out2,
      input locked
   );
endinterface

// File: rtl/clk_wiz.sv
// Divides clk_in1 into two phase-aligned registered clocks with a lock flag.
// Define CLK_WIZ_OUT_GATE_EN to hold both outputs low until lock.
module clk_wiz #(
   parameter int DIV1        = 2,
   parameter int DIV2        = 4,
   parameter int LOCK_CYCLES = 16
) (
   input  logic      clk_in1,
   input  logic      reset,
   clk_wiz_if.master out
);

   if (DIV1 < 2 || DIV1 > 256) begin : g_div1_bad
      $error("clk_wiz: DIV1 must be in 2..256");
   end
   if (DIV2 < 2 || DIV2 > 256) begin : g_div2_bad
      $error("clk_wiz: DIV2 must be in 2..256");
   end
   if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_lock_bad
      $error("clk_wiz: LOCK_CYCLES must be in 1..65535");
   end

   localparam int W1 = $clog2(DIV1);
   localparam int W2 = $clog2(DIV2);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   localparam logic [W1-1:0] TOP1  = W1'(DIV1 - 1);
   localparam logic [W2-1:0] TOP2  = W2'(DIV2 - 1);
   localparam logic [W1-1:0] HIGH1 = W1'(DIV1 / 2);
   localparam logic [W2-1:0] HIGH2 = W2'(DIV2 / 2);

   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);
   localparam logic [LW-1:0] LOCK_M1  = LW'(LOCK_CYCLES - 1);

   logic [W1-1:0] cnt1;
   logic [W2-1:0] cnt2;
   logic [LW-1:0] lock_cnt;

   logic clk1_q;
   logic clk2_q;
   logic locked_q;

   logic term1;
   logic term2;

   // Divider terms use the counter value before this edge's update.
   assign term1 = (cnt1 < HIGH1);
   assign term2 = (cnt2 < HIGH2);

   always_ff @(posedge clk_in1) begin
      if (reset) begin
         cnt1 <= '0;
         cnt2 <= '0;
      end else begin
         cnt1 <= (cnt1 == TOP1) ? '0 : cnt1 + W1'(1);
         cnt2 <= (cnt2 == TOP2) ? '0 : cnt2 + W2'(1);
      end
   end

   always_ff @(posedge clk_in1) begin
      if (reset) begin
         lock_cnt <= '0;
         locked_q <= 1'b0;
      end else begin
         if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + LW'(1);
         end
         if (lock_cnt == LOCK_M1) begin
            locked_q <= 1'b1;
         end
      end
   end

`ifdef CLK_WIZ_OUT_GATE_EN
   logic lock_next;
   logic run1;
   logic run2;
   logic en1;
   logic en2;

   // Each output is released only at its own counter wrap at or after lock,
   // so the first pulse after lock is always a full-width one.
   assign lock_next = locked_q | (lock_cnt == LOCK_M1);
   assign en1 = run1 | (lock_next & (cnt1 == '0));
   assign en2 = run2 | (lock_next & (cnt2 == '0));

   always_ff @(posedge clk_in1) begin
      if (reset) begin
         run1   <= 1'b0;
         run2   <= 1'b0;
         clk1_q <= 1'b0;
         clk2_q <= 1'b0;
      end else begin
         run1   <= en1;
         run2   <= en2;
         clk1_q <= term1 & en1;
         clk2_q <= term2 & en2;
      end
   end
`else
   always_ff @(posedge clk_in1) begin
      if (reset) begin
         clk1_q <= 1'b0;
         clk2_q <= 1'b0;
      end else begin
         clk1_q <= term1;
         clk2_q <= term2;
      end
   end
`endif

   assign out.clk_out1 = clk1_q;
   assign out.clk_out2 = clk2_q;
   assign out.locked   = locked_q;

endmodule

// File: tb/tb_clk_wiz.sv
// Randomized-reset bench for clk_wiz: two parameterizations against an
// edge-count reference model of the divided clocks and lock flag.
module tb_clk_wiz;

   localparam int A_D1 = 2;
   localparam int A_D2 = 4;
   localparam int A_LK = 16;
   localparam int B_D1 = 5;
   localparam int B_D2 = 3;
   localparam int B_LK = 7;

   logic clk_in1;
   logic reset;

   clk_wiz_if bus_a ();
   clk_wiz_if bus_b ();

   clk_wiz #(
      .DIV1        (A_D1),
      .DIV2        (A_D2),
      .LOCK_CYCLES (A_LK)
   ) dut_a (
      .clk_in1 (clk_in1),
      .reset   (reset),
      .out     (bus_a)
   );

   clk_wiz #(
      .DIV1        (B_D1),
      .DIV2        (B_D2),
      .LOCK_CYCLES (B_LK)
   ) dut_b (
      .clk_in1 (clk_in1),
      .reset   (reset),
      .out     (bus_b)
   );

   initial clk_in1 = 1'b0;
   always #5 clk_in1 = ~clk_in1;

   int tests;
   int fails;
   int cyc;

   task automatic check(input string tag, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
      end
   endtask

   // n = index of the most recent non-reset edge since release, -1 in reset.
   function automatic logic ref_clk(input int n, input int div, input int lk);
      logic v;
      int start;
      if (n < 0) return 1'b0;
      v = ((n % div) < (div / 2));
`ifdef CLK_WIZ_OUT_GATE_EN
      start = ((lk - 1 + div - 1) / div) * div;
      v = v && (n >= start);
`else
      start = lk;
`endif
      return v;
   endfunction

   function automatic logic ref_lock(input int n, input int lk);
      return (n >= 0) && (n >= lk - 1);
   endfunction

   int n;

   initial begin
      tests = 0;
      fails = 0;
      n     = -1;
      reset = 1'b1;
      for (int i = 0; i < 1600; i++) begin
         cyc = i;
         @(posedge clk_in1);
         n = reset ? -1 : n + 1;
         #1;
         check("a_clk1", bus_a.clk_out1, ref_clk(n, A_D1, A_LK));
         check("a_clk2", bus_a.clk_out2, ref_clk(n, A_D2, A_LK));
         check("a_lock", bus_a.locked, ref_lock(n, A_LK));
         check("b_clk1", bus_b.clk_out1, ref_clk(n, B_D1, B_LK));
         check("b_clk2", bus_b.clk_out2, ref_clk(n, B_D2, B_LK));
         check("b_lock", bus_b.locked, ref_lock(n, B_LK));
         @(negedge clk_in1);
         if (i < 4) begin
            reset = 1'b1;
         end else if (i < 1130) begin
            reset = 1'b0;
         end else if (i == 1140) begin
            reset = 1'b1;
         end else begin
            reset = ($urandom_range(0, 99) < 2);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
